// File: rtl/shift_arb_pkg.sv
// Shared constants and slot-state type for the shift request arbiter.
package shift_arb_pkg;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int SHW   = 5;
    localparam int IDW   = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;
endpackage

// File: rtl/left_barrel_shifter.sv
// Combinational logical left barrel shifter with zero fill; one stage per shift bit.
module left_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   shift,
    output logic [WIDTH-1:0] B
);
    logic [WIDTH-1:0] stage;

    always_comb begin
        stage = A;
        for (int s = 0; s < SHW; s++) begin
            if (shift[s]) begin
                stage = stage << (1 << s);
            end
        end
        B = stage;
    end
endmodule

// File: rtl/shift_req_arbiter.sv
// Round-robin arbiter sharing one left barrel shifter among NREQ requesters,
// with a single registered output slot held until the consumer accepts it.
module shift_req_arbiter
    import shift_arb_pkg::*;
#(
    parameter int NREQ  = shift_arb_pkg::NREQ,
    parameter int WIDTH = shift_arb_pkg::WIDTH,
    parameter int SHW   = shift_arb_pkg::SHW,
    parameter int IDW   = shift_arb_pkg::IDW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*SHW-1:0]   req_shift,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id
);
    slot_state_e      state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic             slot_free;
    logic             found;
    logic [IDW-1:0]   gnt_idx;
    logic             grant;
    logic [WIDTH-1:0] sel_data;
    logic [SHW-1:0]   sel_shift;
    logic [WIDTH-1:0] shifted;

    // Returns {found, index}: first valid requester at or above p, wrapping.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
        int idx;
        rr_pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (v[idx]) begin
                rr_pick = {1'b1, IDW'(idx)};
            end
        end
    endfunction

    assign slot_free        = (state_q == SLOT_EMPTY) || rsp_ready;
    assign {found, gnt_idx} = rr_pick(req_valid, ptr_q);
    assign grant            = !rst && slot_free && found;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data  = req_data[int'(gnt_idx) * WIDTH +: WIDTH];
        sel_shift = req_shift[int'(gnt_idx) * SHW +: SHW];
    end

    left_barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
        .A     (sel_data),
        .shift (sel_shift),
        .B     (shifted)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        if (grant) begin
            state_d    = SLOT_FULL;
            ptr_d      = IDW'((int'(gnt_idx) + 1) % NREQ);
            rsp_data_d = shifted;
            rsp_id_d   = gnt_idx;
        end else if (state_q == SLOT_FULL && rsp_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SLOT_EMPTY;
            ptr_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == SLOT_FULL);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_shift_req_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_shift_req_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 5;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_data;
    logic [N*SW-1:0] req_shift;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    rsp_data;
    logic [IW-1:0]   rsp_id;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Behavioural model of the output slot and round-robin pointer.
    bit          m_full = 1'b0;
    logic [31:0] m_data = '0;
    int          m_id   = 0;
    int          m_ptr  = 0;
    int          waitc[N];

    shift_req_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shift (req_shift),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_shift(input logic [31:0] a, input int sh);
        return a << (sh % 32);
    endfunction

    always @(negedge clk) begin : cmp
        logic [N-1:0] eg;
        int g;
        int idx;
        eg = '0;
        g  = -1;
        if (!rst && (!m_full || rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        if (check_en) begin
            check("req_ready", 32'(req_ready), 32'(eg));
            check("rsp_valid", 32'(rsp_valid), 32'(m_full));
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        if (rst) begin
            m_full = 1'b0;
            m_data = '0;
            m_id   = 0;
            m_ptr  = 0;
            for (int i = 0; i < N; i++) waitc[i] = 0;
        end else if (g >= 0) begin
            for (int i = 0; i < N; i++) begin
                if (i == g || !req_valid[i]) begin
                    waitc[i] = 0;
                end else begin
                    waitc[i]++;
                    if (check_en) check("fairness", 32'(waitc[i] < N), 32'd1);
                end
            end
            m_full = 1'b1;
            m_data = exp_shift(req_data[g*W +: W], int'(req_shift[g*SW +: SW]));
            m_id   = g;
            m_ptr  = (g + 1) % N;
        end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input int sh);
        req_valid[i]         = 1'b1;
        req_data[i*W +: W]   = d;
        req_shift[i*SW +: SW] = SW'(sh);
    endtask

    task automatic one_shot(input int sh, input logic [31:0] want, input string name);
        req_valid = '0;
        set_req(2, 32'h2D93FB1A, sh);
        @(negedge clk);
        check({name, "_grant"}, 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        check({name, "_data"}, rsp_data, want);
        check({name, "_id"}, 32'(rsp_id), 32'd2);
        step();
    endtask

    initial begin : stim
        logic [31:0] held;
        logic [N-1:0] gnt;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        rst = 1'b1;
        req_valid = '1;
        req_data = '0;
        req_shift = '0;
        rsp_ready = 1'b1;
        step();
        check_en = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        step();
        rst = 1'b0;

        check("model_shift4", exp_shift(32'h2D93FB1A, 4), 32'hD93FB1A0);
        check("model_shift36", exp_shift(32'h2D93FB1A, 36), 32'hD93FB1A0);
        one_shot(4, 32'hD93FB1A0, "single");
        one_shot(0, 32'h2D93FB1A, "shift0");
        one_shot(1, 32'h5B27F634, "shift1");
        one_shot(31, 32'h00000000, "shift31");

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'h1 << i, i);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(1 << (k % N)));
            if (k > 0) check("rr_id", 32'(rsp_id), 32'((k - 1) % N));
            step();
        end

        rsp_ready = 1'b0;
        held = rsp_data;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_grant", 32'(req_ready), 32'd0);
            check("bp_data", rsp_data, held);
            check("bp_id", 32'(rsp_id), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(req_ready), 32'b0010);
        step();

        rst = 1'b1;
        @(negedge clk);
        check("midrst_id_before", 32'(rsp_id), 32'd1);
        check("midrst_grant", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_data", rsp_data, 32'd0);
        check("midrst_first", 32'(req_ready), 32'b0001);
        step();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gnt = req_ready;
            @(posedge clk);
            #1;
            rst = ($urandom_range(99) == 0);
            rsp_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || gnt[i]) begin
                    if ($urandom_range(2) != 0) set_req(i, $urandom, int'($urandom_range(31)));
                    else req_valid[i] = 1'b0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
